// File: rtl/id_ex_pkg.sv
// Shared definitions for the ID/EX stage: payload bundle layout, control-field
// bit positions and a helper that sizes the flattened payload.
package id_ex_pkg;

    localparam int CONTROL_SIZE = 16;
    localparam int DATA_W_DEF   = 32;
    localparam int REG_W_DEF    = 5;
    localparam int OP_W_DEF     = 6;

    // Control bundle bit positions (wb, mem and ex fields)
    localparam int CTRL_REG_WRITE  = 0;
    localparam int CTRL_MEM_TO_REG = 1;
    localparam int CTRL_MEM_READ   = 2;
    localparam int CTRL_MEM_WRITE  = 3;
    localparam int CTRL_BRANCH     = 4;
    localparam int CTRL_ALU_SRC    = 5;
    localparam int CTRL_REG_DST    = 6;
    localparam int CTRL_ALU_OP_LSB = 7;
    localparam int CTRL_ALU_OP_W   = 4;

    typedef struct packed {
        logic [OP_W_DEF-1:0]     opcode;
        logic [CONTROL_SIZE-1:0] control;
        logic [DATA_W_DEF-1:0]   rs_value;
        logic [DATA_W_DEF-1:0]   rt_value;
        logic [DATA_W_DEF-1:0]   offset16;
        logic [REG_W_DEF-1:0]    rs;
        logic [REG_W_DEF-1:0]    rt;
        logic [REG_W_DEF-1:0]    rd;
    } id_ex_payload_t;

    function automatic int payload_width(input int data_w, input int reg_w,
                                         input int op_w, input int ctrl_w);
        return op_w + ctrl_w + 3 * data_w + 3 * reg_w;
    endfunction

endpackage

// File: rtl/pipe_skid_reg.sv
// Generic valid/ready pipeline register over a flat bundle, with optional
// skid entry (registered ready) and a flush that empties both entries.
module pipe_skid_reg #(
    parameter int WIDTH = 8,
    parameter int SKID  = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             main_vld_q, main_vld_d;
    logic [WIDTH-1:0] main_q, main_d;
    logic             accept, consume;

    assign accept    = in_valid && in_ready;
    assign consume   = main_vld_q && out_ready;
    assign out_valid = main_vld_q;
    assign out_data  = main_q;

    generate
        if (SKID != 0) begin : g_skid
            logic             skid_vld_q, skid_vld_d;
            logic [WIDTH-1:0] skid_q, skid_d;
            logic             main_load;

            assign in_ready  = !skid_vld_q;
            assign main_load = !main_vld_q || consume;

            // Skid has priority into main so order is preserved; while skid is
            // full in_ready is low, so no input can race it.
            always_comb begin
                main_vld_d = main_vld_q;
                main_d     = main_q;
                skid_vld_d = skid_vld_q;
                skid_d     = skid_q;
                if (flush) begin
                    main_vld_d = 1'b0;
                    skid_vld_d = 1'b0;
                end else if (main_load) begin
                    if (skid_vld_q) begin
                        main_d     = skid_q;
                        main_vld_d = 1'b1;
                        skid_vld_d = 1'b0;
                    end else begin
                        main_vld_d = accept;
                        if (accept) begin
                            main_d = in_data;
                        end
                    end
                end else if (accept) begin
                    skid_d     = in_data;
                    skid_vld_d = 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    main_vld_q <= 1'b0;
                    main_q     <= '0;
                    skid_vld_q <= 1'b0;
                    skid_q     <= '0;
                end else begin
                    main_vld_q <= main_vld_d;
                    main_q     <= main_d;
                    skid_vld_q <= skid_vld_d;
                    skid_q     <= skid_d;
                end
            end
        end else begin : g_single
            assign in_ready = !main_vld_q || out_ready;

            always_comb begin
                main_vld_d = main_vld_q;
                main_d     = main_q;
                if (flush) begin
                    main_vld_d = 1'b0;
                end else if (accept) begin
                    main_d     = in_data;
                    main_vld_d = 1'b1;
                end else if (consume) begin
                    main_vld_d = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    main_vld_q <= 1'b0;
                    main_q     <= '0;
                end else begin
                    main_vld_q <= main_vld_d;
                    main_q     <= main_d;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: packs the decoded instruction into one bundle, registers
// it with valid/ready handshake, masks control on bubbles and counts bubbles.
module id_ex_stage
    import id_ex_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5,
    parameter int OP_W   = 6,
    parameter int CTRL_W = CONTROL_SIZE,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inValid,
    output logic              inReady,
    input  logic [OP_W-1:0]   opcodeIn,
    input  logic [CTRL_W-1:0] controlIn,
    input  logic [DATA_W-1:0] rsValueIn,
    input  logic [DATA_W-1:0] rtValueIn,
    input  logic [DATA_W-1:0] offset16In,
    input  logic [REG_W-1:0]  rsIn,
    input  logic [REG_W-1:0]  rtIn,
    input  logic [REG_W-1:0]  rdIn,
    input  logic              flush,
    output logic              outValid,
    input  logic              outReady,
    output logic [OP_W-1:0]   opcodeOut,
    output logic [CTRL_W-1:0] controlOut,
    output logic [DATA_W-1:0] rsValueOut,
    output logic [DATA_W-1:0] rtValueOut,
    output logic [DATA_W-1:0] offset16Out,
    output logic [REG_W-1:0]  rsOut,
    output logic [REG_W-1:0]  rtOut,
    output logic [REG_W-1:0]  rdOut,
    output logic [CNT_W-1:0]  bubbleCount
);

    localparam int PAYLOAD_W = payload_width(DATA_W, REG_W, OP_W, CTRL_W);

    logic [PAYLOAD_W-1:0] in_bus, out_bus;
    logic [CTRL_W-1:0]    ctrl_raw;
    logic                 out_valid;
    logic [CNT_W-1:0]     bubble_cnt_q, bubble_cnt_d;

    assign in_bus = {opcodeIn, controlIn, rsValueIn, rtValueIn, offset16In,
                     rsIn, rtIn, rdIn};

    pipe_skid_reg #(
        .WIDTH(PAYLOAD_W),
        .SKID (SKID)
    ) u_reg (
        .clk      (clk),
        .rst      (rst),
        .in_valid (inValid),
        .in_ready (inReady),
        .in_data  (in_bus),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(outReady),
        .out_data (out_bus)
    );

    assign {opcodeOut, ctrl_raw, rsValueOut, rtValueOut, offset16Out,
            rsOut, rtOut, rdOut} = out_bus;

    // A bubble must never write a register or touch memory downstream.
    assign controlOut = out_valid ? ctrl_raw : '0;
    assign outValid   = out_valid;

    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        if (!out_valid && (bubble_cnt_q != {CNT_W{1'b1}})) begin
            bubble_cnt_d = bubble_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bubble_cnt_q <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign bubbleCount = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: table-driven handshake vectors with a payload
// scoreboard, plus hand-written sequences for counter saturation and reset.
module tb_id_ex_stage;

    typedef struct packed {
        logic [5:0]  op;
        logic [15:0] ctrl;
        logic [31:0] rsv;
        logic [31:0] rtv;
        logic [31:0] off;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
    } pl_t;

    typedef struct {
        bit rst;
        bit iv;
        bit ordy;
        bit fl;
        bit chk;
        bit ir;
        bit ov;
        int cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inValid = 1'b0;
    logic        flush = 1'b0;
    logic        outReady = 1'b1;
    logic [5:0]  opcodeIn = '0;
    logic [15:0] controlIn = '0;
    logic [31:0] rsValueIn = '0, rtValueIn = '0, offset16In = '0;
    logic [4:0]  rsIn = '0, rtIn = '0, rdIn = '0;

    logic        ir1, ov1, ir0, ov0, irc, ovc;
    logic [5:0]  op1, op0, opc;
    logic [15:0] ctrl1, ctrl0, ctrlc;
    logic [31:0] rsv1, rtv1, off1, rsv0, rtv0, off0, rsvc, rtvc, offc;
    logic [4:0]  rs1, rt1, rd1, rs0, rt0, rd0, rsc, rtc, rdc;
    logic [15:0] cnt1, cnt0;
    logic [3:0]  cntc;

    int   checks = 0;
    int   errors = 0;
    int   nid = 0;
    pl_t  sb[$];
    vec_t vecs[$];

    always #5 clk = ~clk;

    id_ex_stage #(.DATA_W(32), .REG_W(5), .OP_W(6), .CTRL_W(id_ex_pkg::CONTROL_SIZE),
                  .SKID(1), .CNT_W(16)) u_s1 (
        .clk(clk), .rst(rst), .inValid(inValid), .inReady(ir1),
        .opcodeIn(opcodeIn), .controlIn(controlIn), .rsValueIn(rsValueIn),
        .rtValueIn(rtValueIn), .offset16In(offset16In), .rsIn(rsIn), .rtIn(rtIn),
        .rdIn(rdIn), .flush(flush), .outValid(ov1), .outReady(outReady),
        .opcodeOut(op1), .controlOut(ctrl1), .rsValueOut(rsv1), .rtValueOut(rtv1),
        .offset16Out(off1), .rsOut(rs1), .rtOut(rt1), .rdOut(rd1), .bubbleCount(cnt1));

    id_ex_stage #(.DATA_W(32), .REG_W(5), .OP_W(6), .CTRL_W(id_ex_pkg::CONTROL_SIZE),
                  .SKID(0), .CNT_W(16)) u_s0 (
        .clk(clk), .rst(rst), .inValid(inValid), .inReady(ir0),
        .opcodeIn(opcodeIn), .controlIn(controlIn), .rsValueIn(rsValueIn),
        .rtValueIn(rtValueIn), .offset16In(offset16In), .rsIn(rsIn), .rtIn(rtIn),
        .rdIn(rdIn), .flush(flush), .outValid(ov0), .outReady(outReady),
        .opcodeOut(op0), .controlOut(ctrl0), .rsValueOut(rsv0), .rtValueOut(rtv0),
        .offset16Out(off0), .rsOut(rs0), .rtOut(rt0), .rdOut(rd0), .bubbleCount(cnt0));

    id_ex_stage #(.DATA_W(32), .REG_W(5), .OP_W(6), .CTRL_W(id_ex_pkg::CONTROL_SIZE),
                  .SKID(1), .CNT_W(4)) u_c4 (
        .clk(clk), .rst(rst), .inValid(inValid), .inReady(irc),
        .opcodeIn(opcodeIn), .controlIn(controlIn), .rsValueIn(rsValueIn),
        .rtValueIn(rtValueIn), .offset16In(offset16In), .rsIn(rsIn), .rtIn(rtIn),
        .rdIn(rdIn), .flush(flush), .outValid(ovc), .outReady(outReady),
        .opcodeOut(opc), .controlOut(ctrlc), .rsValueOut(rsvc), .rtValueOut(rtvc),
        .offset16Out(offc), .rsOut(rsc), .rtOut(rtc), .rdOut(rdc), .bubbleCount(cntc));

    function automatic pl_t mk(input int id);
        pl_t        p;
        logic [7:0] b;
        b     = id[7:0];
        p.op  = 6'h23 + id[5:0];
        p.ctrl = 16'hA5C3 ^ {b, b};
        p.rsv = 32'h1000 + 32'(id) * 32'd16;
        p.rtv = 32'hBEEF_0000 + 32'(id);
        p.off = 32'hFFFF_FFFF - 32'(id);
        p.rs  = id[4:0] + 5'd1;
        p.rt  = id[4:0] + 5'd2;
        p.rd  = 5'd8 + id[4:0];
        return p;
    endfunction

    task automatic drive_payload();
        pl_t p;
        p = mk(nid);
        opcodeIn   = p.op;
        controlIn  = p.ctrl;
        rsValueIn  = p.rsv;
        rtValueIn  = p.rtv;
        offset16In = p.off;
        rsIn       = p.rs;
        rtIn       = p.rt;
        rdIn       = p.rd;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic void add(input bit r, input bit iv, input bit ordy, input bit fl,
                                input bit c, input bit ir, input bit ov, input int cnt);
        vec_t v;
        v.rst = r; v.iv = iv; v.ordy = ordy; v.fl = fl;
        v.chk = c; v.ir = ir; v.ov = ov; v.cnt = cnt;
        vecs.push_back(v);
    endfunction

    // Called at the negedge: handshake checks, then scoreboard pop/push.
    task automatic observe(input int sel, input vec_t v, output bit adv);
        logic        ir_s, ov_s;
        logic [15:0] cnt_s;
        pl_t         got, exp;
        if (sel == 0) begin
            ir_s = ir1; ov_s = ov1; cnt_s = cnt1;
            got = {op1, ctrl1, rsv1, rtv1, off1, rs1, rt1, rd1};
        end else begin
            ir_s = ir0; ov_s = ov0; cnt_s = cnt0;
            got = {op0, ctrl0, rsv0, rtv0, off0, rs0, rt0, rd0};
        end
        adv = 1'b0;
        if (v.chk) begin
            chk("inReady", 32'(ir_s), 32'(v.ir));
            chk("outValid", 32'(ov_s), 32'(v.ov));
            chk("bubbleCount", 32'(cnt_s), 32'(v.cnt));
        end
        if (rst) begin
            sb.delete();
        end else begin
            if (ov_s !== 1'b1) begin
                chk("ctrl_bubble", 32'(got.ctrl), 32'h0);
            end else if (outReady) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output_op", 32'(got.op), 32'hFFFF_FFFF);
                end else begin
                    exp = sb.pop_front();
                    chk("opcodeOut", 32'(got.op), 32'(exp.op));
                    chk("controlOut", 32'(got.ctrl), 32'(exp.ctrl));
                    chk("rsValueOut", got.rsv, exp.rsv);
                    chk("rtValueOut", got.rtv, exp.rtv);
                    chk("offset16Out", got.off, exp.off);
                    chk("rsOut", 32'(got.rs), 32'(exp.rs));
                    chk("rtOut", 32'(got.rt), 32'(exp.rt));
                    chk("rdOut", 32'(got.rd), 32'(exp.rd));
                end
            end
            if (flush) begin
                sb.delete();
                adv = 1'b1;
            end else if (inValid && ir_s) begin
                sb.push_back(mk(nid));
                adv = 1'b1;
            end
        end
    endtask

    task automatic run_table(input int sel);
        bit adv;
        for (int i = 0; i < vecs.size(); i++) begin
            rst      = vecs[i].rst;
            inValid  = vecs[i].iv;
            outReady = vecs[i].ordy;
            flush    = vecs[i].fl;
            @(negedge clk);
            observe(sel, vecs[i], adv);
            @(posedge clk);
            #1;
            if (adv) nid++;
            drive_payload();
        end
        chk("scoreboard_empty", 32'(sb.size()), 32'h0);
        vecs.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        drive_payload();
        @(posedge clk);
        #1;

        // SKID=1: reset, single instr, 8-instr stream, stall, flushes
        //   rst iv or fl chk ir ov cnt
        add(1, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 1, 0, 1, 1, 0, 0);
        add(0, 1, 1, 0, 1, 1, 0, 1);
        for (int k = 0; k < 7; k++) add(0, 1, 1, 0, 1, 1, 1, 2);
        add(0, 0, 1, 0, 1, 1, 1, 2);
        add(0, 0, 1, 0, 1, 1, 0, 2);
        add(0, 1, 0, 0, 1, 1, 0, 3);
        add(0, 1, 0, 0, 1, 1, 1, 4);
        add(0, 1, 0, 0, 1, 0, 1, 4);
        add(0, 1, 1, 0, 1, 0, 1, 4);
        add(0, 1, 1, 0, 1, 1, 1, 4);
        add(0, 0, 1, 0, 1, 1, 1, 4);
        add(0, 0, 0, 0, 1, 1, 0, 4);
        add(0, 1, 0, 0, 1, 1, 0, 5);
        add(0, 1, 0, 0, 1, 1, 1, 6);
        add(0, 1, 0, 1, 1, 0, 1, 6);
        add(0, 0, 1, 0, 1, 1, 0, 6);
        add(0, 0, 1, 0, 1, 1, 0, 7);
        add(0, 1, 1, 0, 1, 1, 0, 8);
        add(0, 1, 1, 1, 1, 1, 1, 9);
        add(0, 0, 1, 0, 1, 1, 0, 9);
        add(0, 0, 1, 0, 1, 1, 0, 10);
        run_table(0);

        // SKID=0: combinational stall, back-to-back replacement, flush
        add(1, 0, 1, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 1, 1, 0, 0);
        add(0, 1, 0, 0, 1, 0, 1, 1);
        add(0, 1, 0, 0, 1, 0, 1, 1);
        add(0, 1, 1, 0, 1, 1, 1, 1);
        add(0, 1, 1, 0, 1, 1, 1, 1);
        add(0, 0, 1, 0, 1, 1, 1, 1);
        add(0, 0, 1, 0, 1, 1, 0, 1);
        add(0, 1, 0, 0, 1, 1, 0, 2);
        add(0, 1, 0, 1, 1, 0, 1, 3);
        add(0, 0, 0, 0, 1, 1, 0, 3);
        run_table(1);

        // Saturation at CNT_W=4, then reset together with flush and input
        rst = 1'b1; inValid = 1'b0; flush = 1'b0; outReady = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        chk("cnt4_saturated", 32'(cntc), 32'hF);
        repeat (3) @(posedge clk);
        #1;
        chk("cnt4_holds", 32'(cntc), 32'hF);
        chk("cnt16_no_sat", 32'(cnt1), 32'd23);
        inValid = 1'b1; outReady = 1'b0;
        @(posedge clk); #1;
        chk("c4_loaded", 32'(ovc), 32'h1);
        rst = 1'b1; flush = 1'b1; inValid = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; flush = 1'b0; inValid = 1'b0;
        chk("rst_outValid", 32'(ovc), 32'h0);
        chk("rst_controlOut", 32'(ctrlc), 32'h0);
        chk("rst_opcodeOut", 32'(opc), 32'h0);
        chk("rst_rsValueOut", rsvc, 32'h0);
        chk("rst_rdOut", 32'(rdc), 32'h0);
        chk("rst_bubbleCount", 32'(cntc), 32'h0);
        chk("rst_inReady", 32'(irc), 32'h1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
